// File: rtl/ram_access_controller_pkg.sv
// Shared definitions for the byte-serial RAM access controller: funct3 codes,
// FSM states and request decode helpers.
package ram_access_controller_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 2;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DRAIN,
    ST_RESP
  } state_e;

  // Index of the final byte of an access: 0, 1 or 3 for byte, half, word.
  function automatic logic [CNT_W-1:0] last_index(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  // Request is rejected before touching RAM: unknown size, unsigned store, or misaligned.
  function automatic logic req_invalid(input logic       write,
                                       input logic [2:0] f3,
                                       input logic [1:0] addr_lo,
                                       input logic       chk_align);
    logic bad;
    case (f3)
      F3_B, F3_H, F3_W, F3_BU, F3_HU: bad = 1'b0;
      default:                        bad = 1'b1;
    endcase
    if (write && f3[2]) bad = 1'b1;
    if (chk_align && (f3[1:0] == 2'b01) && addr_lo[0]) bad = 1'b1;
    if (chk_align && (f3[1:0] == 2'b10) && (addr_lo != 2'b00)) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/ram_access_controller_if.sv
// Request/response handshake between the memory stage and the RAM access controller.
interface ram_access_controller_if;
  import ram_access_controller_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_address;
  logic [DATA_W-1:0] req_write_data;
  logic              resp_valid;
  logic              resp_error;
  logic [DATA_W-1:0] resp_read_data;

  modport master (
    output req_valid, req_write, req_funct3, req_address, req_write_data,
    input  req_ready, resp_valid, resp_error, resp_read_data
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_address, req_write_data,
    output req_ready, resp_valid, resp_error, resp_read_data
  );

endinterface

// File: rtl/ram_access_controller_load_extender.sv
// Sign/zero-extends assembled load data according to the load funct3.
module load_extender
  import ram_access_controller_pkg::*;
(
  input  logic [DATA_W-1:0] raw_i,
  input  logic [2:0]        funct3_i,
  output logic [DATA_W-1:0] extended_o
);

  always_comb begin
    case (funct3_i)
      F3_B:    extended_o = {{24{raw_i[7]}}, raw_i[7:0]};
      F3_H:    extended_o = {{16{raw_i[15]}}, raw_i[15:0]};
      F3_BU:   extended_o = {24'h0, raw_i[7:0]};
      F3_HU:   extended_o = {16'h0, raw_i[15:0]};
      default: extended_o = raw_i;
    endcase
  end

endmodule

// File: rtl/ram_access_controller.sv
// Sequences byte/half/word loads and stores into a byte-wide synchronous RAM,
// one little-endian byte per cycle, and reports illegal accesses.
module ram_access_controller
  import ram_access_controller_pkg::*;
#(
  parameter bit ERROR_ON_MISALIGNED = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  ram_access_controller_if.slave bus,
  output logic [ADDR_W-1:0]     ram_address,
  output logic [BYTE_W-1:0]     ram_write_data,
  output logic                  ram_write_enable,
  input  logic [BYTE_W-1:0]     ram_read_data,
  input  logic                  ram_illegal_address
);

  state_e            state_q;
  logic              req_ready_q;
  logic              resp_valid_q;
  logic              resp_error_q;
  logic [DATA_W-1:0] resp_data_q;
  logic              write_q;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wsh_q;
  logic [DATA_W-1:0] asm_q;
  logic [DATA_W-1:0] asm_d;
  logic [DATA_W-1:0] ext_data;
  logic [CNT_W-1:0]  last_idx;
  logic [CNT_W-1:0]  cap_idx;
  logic              capture;
  logic              bad_req;

  assign bad_req  = req_invalid(bus.req_write, bus.req_funct3, bus.req_address[1:0],
                                ERROR_ON_MISALIGNED);
  assign last_idx = last_index(f3_q);

  // Read data lags the address by one cycle, so byte k lands while byte k+1 is issued.
  assign capture = !write_q && (((state_q == ST_ACCESS) && (cnt_q != '0)) || (state_q == ST_DRAIN));
  assign cap_idx = (state_q == ST_DRAIN) ? last_idx : cnt_q - 2'd1;

  always_comb begin
    asm_d = asm_q;
    if (capture) asm_d[{cap_idx, 3'b000} +: BYTE_W] = ram_read_data;
  end

  load_extender u_ext (
    .raw_i      (asm_d),
    .funct3_i   (f3_q),
    .extended_o (ext_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      resp_data_q  <= '0;
      write_q      <= 1'b0;
      we_q         <= 1'b0;
      f3_q         <= '0;
      cnt_q        <= '0;
      addr_q       <= '0;
      wsh_q        <= '0;
      asm_q        <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            req_ready_q <= 1'b0;
            write_q     <= bus.req_write;
            f3_q        <= bus.req_funct3;
            addr_q      <= bus.req_address;
            wsh_q       <= bus.req_write_data;
            cnt_q       <= '0;
            asm_q       <= '0;
            if (bad_req) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_error_q <= 1'b1;
            end else begin
              state_q <= ST_ACCESS;
              we_q    <= bus.req_write;
            end
          end
        end

        ST_ACCESS: begin
          asm_q <= asm_d;
          if (ram_illegal_address) begin
            we_q         <= 1'b0;
            state_q      <= ST_RESP;
            resp_valid_q <= 1'b1;
            resp_error_q <= 1'b1;
          end else if (cnt_q == last_idx) begin
            we_q <= 1'b0;
            if (write_q) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
            end else begin
              state_q <= ST_DRAIN;
            end
          end else begin
            cnt_q  <= cnt_q + 2'd1;
            addr_q <= addr_q + 32'd1;
            wsh_q  <= {8'h00, wsh_q[DATA_W-1:BYTE_W]};
          end
        end

        ST_DRAIN: begin
          asm_q        <= asm_d;
          resp_data_q  <= ext_data;
          resp_valid_q <= 1'b1;
          state_q      <= ST_RESP;
        end

        default: begin
          state_q      <= ST_IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
          resp_error_q <= 1'b0;
          resp_data_q  <= '0;
        end
      endcase
    end
  end

  assign bus.req_ready      = req_ready_q;
  assign bus.resp_valid     = resp_valid_q;
  assign bus.resp_error     = resp_error_q;
  assign bus.resp_read_data = resp_data_q;

  assign ram_address      = addr_q;
  assign ram_write_data   = wsh_q[BYTE_W-1:0];
  // Writes to an illegal address are dropped in the same cycle the RAM flags them.
  assign ram_write_enable = we_q & ~ram_illegal_address;

endmodule

// File: tb/tb_ram_access_controller.sv
// Randomized bench for ram_access_controller: two instances (misalignment legal / rejected)
// share one byte RAM, checked against a transaction-level memory model.
module tb_ram_access_controller;
  import ram_access_controller_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic mem_init;
  bit   sel;
  int   n_checks = 0;
  int   n_fail   = 0;

  ram_access_controller_if bus0 ();
  ram_access_controller_if bus1 ();

  logic [31:0] ram_address0, ram_address1;
  logic [7:0]  ram_wdata0, ram_wdata1;
  logic        ram_we0, ram_we1;
  logic        illegal0, illegal1;
  logic [7:0]  rd_q;
  logic [7:0]  mem [0:8191];
  logic [7:0]  ref_mem [0:8191];

  logic        s_ready, s_rv, s_re, s_we;
  logic [31:0] s_rdata, s_addr;
  logic [7:0]  s_wdata;

  always #5 clk = ~clk;

  ram_access_controller #(.ERROR_ON_MISALIGNED(1'b0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0),
    .ram_address(ram_address0), .ram_write_data(ram_wdata0), .ram_write_enable(ram_we0),
    .ram_read_data(rd_q), .ram_illegal_address(illegal0)
  );

  ram_access_controller #(.ERROR_ON_MISALIGNED(1'b1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1),
    .ram_address(ram_address1), .ram_write_data(ram_wdata1), .ram_write_enable(ram_we1),
    .ram_read_data(rd_q), .ram_illegal_address(illegal1)
  );

  assign illegal0 = (ram_address0 >= 32'h2000);
  assign illegal1 = (ram_address1 >= 32'h2000);
  assign s_ready  = sel ? bus1.req_ready      : bus0.req_ready;
  assign s_rv     = sel ? bus1.resp_valid     : bus0.resp_valid;
  assign s_re     = sel ? bus1.resp_error     : bus0.resp_error;
  assign s_rdata  = sel ? bus1.resp_read_data : bus0.resp_read_data;
  assign s_addr   = sel ? ram_address1        : ram_address0;
  assign s_wdata  = sel ? ram_wdata1          : ram_wdata0;
  assign s_we     = sel ? ram_we1             : ram_we0;

  // Byte RAM: registered read, write on enable.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 8192; i++) mem[i] <= 8'(i * 7 + 3);
    end else if (s_we) begin
      mem[s_addr[12:0]] <= s_wdata;
    end
    rd_q <= mem[s_addr[12:0]];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit s, input bit v, input bit wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    bus0.req_valid = v && !s;       bus1.req_valid = v && s;
    bus0.req_write = wr;            bus1.req_write = wr;
    bus0.req_funct3 = f3;           bus1.req_funct3 = f3;
    bus0.req_address = a;           bus1.req_address = a;
    bus0.req_write_data = wd;       bus1.req_write_data = wd;
  endtask

  task automatic drive_junk(input bit s);
    drive(s, 1'b0, 1'($urandom), 3'($urandom), $urandom, $urandom);
  endtask

  // Transaction-level model: latency, error, load result and number of bytes written.
  task automatic model(input bit p1, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output int lat, output bit err,
                       output logic [31:0] data, output int nwr);
    int n;
    bit bad;
    logic [31:0] raw, ak;
    bad = 1'b0; err = 1'b0; data = 32'h0; raw = 32'h0; nwr = 0;
    case (f3)
      3'd0, 3'd4: n = 1;
      3'd1, 3'd5: n = 2;
      3'd2:       n = 4;
      default: begin n = 0; bad = 1'b1; end
    endcase
    if (wr && f3[2]) bad = 1'b1;
    if (p1 && n > 1 && (a % 32'(n)) != 0) bad = 1'b1;
    if (bad) begin
      lat = 1; err = 1'b1;
      return;
    end
    lat = wr ? n + 1 : n + 2;
    for (int k = 0; k < n; k++) begin
      ak = a + 32'(k);
      if (ak >= 32'h2000) begin
        err = 1'b1; lat = k + 2;
        break;
      end
      if (wr) begin
        ref_mem[ak[12:0]] = wd[8*k +: 8];
        nwr++;
      end else begin
        raw[8*k +: 8] = ref_mem[ak[12:0]];
      end
    end
    if (!wr && !err) begin
      case (f3)
        3'd0:    data = raw[7] ? (raw | 32'hFFFFFF00) : raw;
        3'd1:    data = raw[15] ? (raw | 32'hFFFF0000) : raw;
        default: data = raw;
      endcase
    end
  endtask

  task automatic wait_ready();
    int waited = 0;
    while (!s_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    check_eq("ready_before_req", 32'(s_ready), 32'd1);
  endtask

  task automatic run_txn(input bit s, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output int lat, output bit err,
                         output logic [31:0] data, output int nwr);
    int e_lat, e_nwr;
    bit e_err;
    logic [31:0] e_data;
    logic ready1;
    sel = s;
    #1;
    wait_ready();
    drive(s, 1'b1, wr, f3, a, wd);
    @(posedge clk); #1;
    drive_junk(s);
    lat = -1; err = 1'b0; data = 32'hDEAD_BEEF; nwr = 0; ready1 = s_ready;
    for (int c = 1; c <= 20; c++) begin
      if (s_we) nwr++;
      if (s_rv) begin
        lat = c; err = s_re; data = s_rdata;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    model(s, wr, f3, a, wd, e_lat, e_err, e_data, e_nwr);
    check_eq("busy_cycle1", 32'(ready1), 32'd0);
    check_eq("latency", 32'(lat), 32'(e_lat));
    check_eq("resp_error", 32'(err), 32'(e_err));
    check_eq("resp_data", data, e_data);
    check_eq("write_count", 32'(nwr), 32'(e_nwr));
    check_eq("idle_after_resp", {30'h0, s_ready, s_rv}, 32'h2);
  endtask

  int          lat, nwr, bad_cycles;
  bit          err;
  logic [31:0] data, a;
  logic [2:0]  f3;
  logic [2:0]  f3_tab [0:4];

  initial begin
    f3_tab[0] = F3_B; f3_tab[1] = F3_H; f3_tab[2] = F3_W; f3_tab[3] = F3_BU; f3_tab[4] = F3_HU;
    for (int i = 0; i < 8192; i++) ref_mem[i] = 8'(i * 7 + 3);
    reset = 1'b1; mem_init = 1'b1; sel = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    mem_init = 1'b0;
    check_eq("rst_ready", 32'(bus0.req_ready), 32'd1);
    check_eq("rst_resp", {30'h0, bus0.resp_valid, bus0.resp_error}, 32'h0);
    check_eq("rst_rdata", bus0.resp_read_data, 32'h0);
    check_eq("rst_ram_addr", ram_address0, 32'h0);
    check_eq("rst_ram_we", 32'(ram_we0), 32'd0);
    reset = 1'b0;

    // Word store/load round trip.
    run_txn(0, 1, F3_W, 32'h10, 32'h11223344, lat, err, data, nwr);
    check_eq("t1_sw_lat", 32'(lat), 32'd5);
    check_eq("t1_sw_err", 32'(err), 32'd0);
    run_txn(0, 0, F3_W, 32'h10, 32'h0, lat, err, data, nwr);
    check_eq("t1_lw_lat", 32'(lat), 32'd6);
    check_eq("t1_lw_data", data, 32'h11223344);

    // Byte sign/zero extension.
    run_txn(0, 1, F3_B, 32'h21, 32'h80, lat, err, data, nwr);
    run_txn(0, 0, F3_B, 32'h21, 32'h0, lat, err, data, nwr);
    check_eq("t2_lb", data, 32'hFFFFFF80);
    run_txn(0, 0, F3_BU, 32'h21, 32'h0, lat, err, data, nwr);
    check_eq("t2_lbu", data, 32'h00000080);

    // Misaligned halfword: performed when allowed, rejected otherwise.
    run_txn(0, 1, F3_H, 32'h23, 32'hBEEF, lat, err, data, nwr);
    check_eq("t3_mem23", 32'(mem[13'h23]), 32'hEF);
    check_eq("t3_mem24", 32'(mem[13'h24]), 32'hBE);
    run_txn(0, 0, F3_HU, 32'h23, 32'h0, lat, err, data, nwr);
    check_eq("t3_lhu", data, 32'h0000BEEF);
    run_txn(1, 1, F3_H, 32'h23, 32'h1234, lat, err, data, nwr);
    check_eq("t3_p1_lat", 32'(lat), 32'd1);
    check_eq("t3_p1_err", 32'(err), 32'd1);
    check_eq("t3_p1_we", 32'(nwr), 32'd0);
    check_eq("t3_p1_mem23", 32'(mem[13'h23]), 32'hEF);
    run_txn(1, 0, F3_W, 32'h10, 32'h0, lat, err, data, nwr);
    check_eq("t3_p1_lw", data, 32'h11223344);

    // Word store running off the end of legal RAM.
    run_txn(0, 1, F3_W, 32'h1FFE, 32'hAABBCCDD, lat, err, data, nwr);
    check_eq("t4_lat", 32'(lat), 32'd4);
    check_eq("t4_err", 32'(err), 32'd1);
    check_eq("t4_mem1ffe", 32'(mem[13'h1FFE]), 32'hDD);
    check_eq("t4_mem1fff", 32'(mem[13'h1FFF]), 32'hCC);

    // Invalid funct3 for load and store.
    run_txn(0, 0, 3'b011, 32'h40, 32'h0, lat, err, data, nwr);
    check_eq("t5_ld_lat", 32'(lat), 32'd1);
    check_eq("t5_ld_err", 32'(err), 32'd1);
    run_txn(0, 1, 3'b100, 32'h40, 32'h55, lat, err, data, nwr);
    check_eq("t5_st_lat", 32'(lat), 32'd1);
    check_eq("t5_st_err", 32'(err), 32'd1);

    // Reset during cycle 2 of a word store.
    sel = 1'b0;
    wait_ready();
    drive(0, 1, 1, F3_W, 32'h40, 32'hCAFEF00D);
    @(posedge clk); #1;
    drive_junk(0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_eq("t6_ready", 32'(s_ready), 32'd1);
    check_eq("t6_resp", 32'(s_rv), 32'd0);
    check_eq("t6_we", 32'(s_we), 32'd0);
    bad_cycles = 0;
    repeat (6) begin
      if (s_we || s_rv) bad_cycles++;
      @(posedge clk); #1;
    end
    check_eq("t6_quiet", 32'(bad_cycles), 32'd0);
    ref_mem[13'h40] = 8'h0D;
    ref_mem[13'h41] = 8'hF0;
    check_eq("t6_mem42", 32'(mem[13'h42]), 32'(ref_mem[13'h42]));
    run_txn(0, 0, F3_W, 32'h40, 32'h0, lat, err, data, nwr);
    check_eq("t6_lw_low", data & 32'hFFFF, 32'hF00D);

    // Random traffic over both instances.
    for (int t = 0; t < 200; t++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: a = 32'($urandom_range(0, 63));
        6, 7, 8:          a = 32'h1FF0 + 32'($urandom_range(0, 31));
        default:          a = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
      endcase
      f3 = ($urandom_range(0, 9) < 8) ? f3_tab[$urandom_range(0, 4)] : 3'($urandom);
      run_txn(($urandom_range(0, 3) == 0), 1'($urandom), f3, a, $urandom, lat, err, data, nwr);
    end

    for (int i = 0; i < 128; i++) begin
      check_eq("mem_lo", 32'(mem[i]), 32'(ref_mem[i]));
      check_eq("mem_hi", 32'(mem[8064 + i]), 32'(ref_mem[8064 + i]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
